irq_conditioner: RTL and testbench

- Front-end stage that sits directly upstream of the interrupt controller and drives its irq[3:0] inputs.
- Synchronises raw asynchronous interrupt lines and applies per-line edge or level detection.
- Latches edge events into a pending register and applies a per-line mask.
- Clears pending bits using the controller's int_ack / int_id handshake, so edge pulses are never lost while the controller is busy.

---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_sync_edge.sv | 80 ++++++++
 rtl/irq_conditioner.sv | 94 +++++++++
 tb/tb_irq_conditioner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt conditioner and the controller it feeds.
// Optional glitch filter is enabled with the IRQ_GLITCH_FILTER_EN macro.
package irq_pkg;

    localparam int N_IRQ_DEF       = 4;
    localparam int ID_W_DEF        = 2;
    localparam int SYNC_STAGES_DEF = 2;
`ifdef IRQ_GLITCH_FILTER_EN
    localparam int FILT_CYCLES_DEF = 3;
`endif

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: synchroniser chain, optional glitch filter, history flop and rise detect.
// The filter is built only when IRQ_GLITCH_FILTER_EN is defined.
module irq_sync_edge
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef IRQ_GLITCH_FILTER_EN
    ,
    parameter int FILT_CYCLES = FILT_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;
    logic                   filt_s;
    logic                   hist_q;
    logic                   hist_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign sync_s = sync_q[SYNC_STAGES-1];
    assign hist_d = filt_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

`ifdef IRQ_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;

    // The counter only runs while the synced input disagrees with the filtered value.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_s == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(FILT_CYCLES - 1)) begin
            filt_d = sync_s;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_s = filt_q;
`else
    assign filt_s = sync_s;
`endif

    assign filt_o = filt_s;
    assign rise_o = filt_s & ~hist_q;

endmodule

// File: rtl/irq_conditioner.sv
// Interrupt front end: per-line sync/edge detect, pending and overflow latching, ack clearing.
// Optional glitch filter per line is enabled with the IRQ_GLITCH_FILTER_EN macro.
module irq_conditioner
    import irq_pkg::*;
#(
    parameter int N_IRQ       = N_IRQ_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef IRQ_GLITCH_FILTER_EN
    ,
    parameter int FILT_CYCLES = FILT_CYCLES_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_raw,
    input  logic [N_IRQ-1:0] edge_mode,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             int_ack,
    input  logic [ID_W-1:0]  int_id,
    input  logic             ovf_clr,
    output logic [N_IRQ-1:0] irq,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] overflow
);

    logic [N_IRQ-1:0] filt_s;
    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] clr_s;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] overflow_q;
    logic [N_IRQ-1:0] overflow_d;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef IRQ_GLITCH_FILTER_EN
            ,
            .FILT_CYCLES (FILT_CYCLES)
`endif
        ) u_sync_edge (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (irq_raw[g]),
            .filt_o (filt_s[g]),
            .rise_o (rise_s[g])
        );

        // Out-of-range ids match no line, so they clear nothing.
        assign clr_s[g] = int_ack & (int_id == ID_W'(g));
    end

    // A new rise beats a same-cycle ack; it only overflows when nothing was cleared.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q & ~{N_IRQ{ovf_clr}};
        for (int i = 0; i < N_IRQ; i++) begin
            case (edge_mode[i])
                MODE_EDGE: begin
                    if (rise_s[i]) begin
                        pending_d[i] = 1'b1;
                        if (pending_q[i] && !clr_s[i]) begin
                            overflow_d[i] = 1'b1;
                        end else begin
                            overflow_d[i] = overflow_d[i];
                        end
                    end else if (clr_s[i]) begin
                        pending_d[i] = 1'b0;
                    end else begin
                        pending_d[i] = pending_q[i];
                    end
                end
                MODE_LEVEL: pending_d[i] = filt_s[i];
                default:    pending_d[i] = pending_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign irq      = pending_q & irq_mask;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Self-checking bench for irq_conditioner: directed vector table, hand sequences and random traffic vs a model.
module tb_irq_conditioner;
    import irq_pkg::*;

    localparam int N = 4;
    localparam int S = 2;
`ifdef IRQ_GLITCH_FILTER_EN
    localparam int F = 3;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_raw;
    logic [N-1:0] edge_mode;
    logic [N-1:0] irq_mask;
    logic         int_ack;
    logic [1:0]   int_id;
    logic         ovf_clr;
    logic [N-1:0] irq;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;

    int checks = 0;
    int errors = 0;

    irq_conditioner #(.N_IRQ(N), .ID_W(2), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_raw   (irq_raw),
        .edge_mode (edge_mode),
        .irq_mask  (irq_mask),
        .int_ack   (int_ack),
        .int_id    (int_id),
        .ovf_clr   (ovf_clr),
        .irq       (irq),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw samples in a delay queue, filtered value, history, pending, overflow.
    logic [N-1:0] raw_q[$];
    logic [N-1:0] sh[$];
    logic [N-1:0] m_f, m_fd, m_pend, m_ovf;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        sh.delete();
        m_f = '0; m_fd = '0; m_pend = '0; m_ovf = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] rise, np, no, nf;
        logic         clr;
        rise = m_f & ~m_fd;
        np   = m_pend;
        no   = m_ovf & ~{N{ovf_clr}};
        for (int i = 0; i < N; i++) begin
            clr = int_ack && (int'(int_id) == i);
            if (!edge_mode[i]) np[i] = m_f[i];
            else if (rise[i]) begin
                if (m_pend[i] && !clr) no[i] = 1'b1;
                np[i] = 1'b1;
            end else if (clr) np[i] = 1'b0;
        end
`ifdef IRQ_GLITCH_FILTER_EN
        begin
            logic [N-1:0] s_pre;
            logic         all_diff;
            s_pre = (raw_q.size() >= S) ? raw_q[S-1] : '0;
            sh.push_front(s_pre);
            while (sh.size() > F) void'(sh.pop_back());
            nf = m_f;
            if (sh.size() == F) begin
                for (int i = 0; i < N; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < F; j++) if (sh[j][i] == m_f[i]) all_diff = 1'b0;
                    if (all_diff) nf[i] = ~m_f[i];
                end
            end
        end
`endif
        raw_q.push_front(irq_raw);
        while (raw_q.size() > S) void'(raw_q.pop_back());
`ifndef IRQ_GLITCH_FILTER_EN
        nf = (raw_q.size() >= S) ? raw_q[S-1] : '0;
`endif
        m_fd = m_f; m_f = nf; m_pend = np; m_ovf = no;
    endtask

    // One clock: advance the model with the present inputs, then compare just after the edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("model_pending", pending, m_pend);
        chk("model_irq", irq, m_pend & irq_mask);
        chk("model_overflow", overflow, m_ovf);
        int_ack = 1'b0;
        ovf_clr = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] mask;
        logic         ack;
        logic [1:0]   id;
        logic         oclr;
        logic [N-1:0] ep;
        logic [N-1:0] ei;
        logic [N-1:0] eo;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [N-1:0] raw, input logic [N-1:0] mask, input logic ack, input logic [1:0] id,
                       input logic oclr, input logic [N-1:0] ep, input logic [N-1:0] ei, input logic [N-1:0] eo);
        vec_t v;
        v.raw = raw; v.mask = mask; v.ack = ack; v.id = id; v.oclr = oclr; v.ep = ep; v.ei = ei; v.eo = eo;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0; irq_raw = '0; edge_mode = 4'b1111; irq_mask = 4'b1111;
        int_ack = 1'b0; int_id = 2'd0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pending", pending, 4'b0000);
        chk("reset_irq", irq, 4'b0000);
        chk("reset_overflow", overflow, 4'b0000);
        rst = 1'b1;
        cyc();

`ifndef IRQ_GLITCH_FILTER_EN
        // raw, mask, ack, id, oclr, pending, irq, overflow (values after the clock)
        add(4'b0001, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0010, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0010);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0010, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0100, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0100, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0100, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1000, 4'b0111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1000, 4'b0111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0000, 4'b0111, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b0000);
        for (int k = 0; k < tbl.size(); k++) begin
            irq_raw = tbl[k].raw; irq_mask = tbl[k].mask;
            int_ack = tbl[k].ack; int_id = tbl[k].id; ovf_clr = tbl[k].oclr;
            cyc();
            chk($sformatf("vec%0d_pending", k), pending, tbl[k].ep);
            chk($sformatf("vec%0d_irq", k), irq, tbl[k].ei);
            chk($sformatf("vec%0d_overflow", k), overflow, tbl[k].eo);
        end

        // Unmasking a pending line raises irq without waiting for a clock.
        irq_mask = 4'b1111;
        #1;
        chk("unmask_same_cycle_irq", irq, 4'b1000);
        int_ack = 1'b1; int_id = 2'd3;
        cyc();
        chk("ack3_pending", pending, 4'b0000);

        // Level mode on line 2: pending follows the synced input, acks are ignored.
        edge_mode = 4'b1011;
        for (int k = 1; k <= 14; k++) begin
            irq_raw = (k <= 10) ? 4'b0100 : 4'b0000;
            if (k == 6) begin int_ack = 1'b1; int_id = 2'd2; end
            cyc();
            chk($sformatf("level_k%0d_pending", k), pending, (k >= 3 && k <= 12) ? 4'b0100 : 4'b0000);
            chk($sformatf("level_k%0d_overflow", k), overflow, 4'b0000);
        end
        edge_mode = 4'b1111;
        cyc();
`else
        // Short pulse is swallowed by the filter.
        irq_raw = 4'b0001; cyc(); cyc();
        irq_raw = 4'b0000;
        for (int k = 0; k < 8; k++) cyc();
        chk("filt_short_pending", pending, 4'b0000);
        // Five-cycle pulse reaches irq six clocks after the rise.
        for (int k = 1; k <= 9; k++) begin
            irq_raw = (k <= 5) ? 4'b0001 : 4'b0000;
            cyc();
            chk($sformatf("filt_lat_k%0d_irq", k), irq, (k >= 6) ? 4'b0001 : 4'b0000);
        end
        for (int k = 0; k < 6; k++) cyc();
        int_ack = 1'b1; int_id = 2'd0;
        cyc();
        chk("filt_ack_pending", pending, 4'b0000);
`endif

        // Asynchronous reset in the middle of a pulse.
        irq_raw = 4'b0001;
        for (int k = 0; k < 8; k++) cyc();
        chk("pre_reset_pending", pending, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_pending", pending, 4'b0000);
        chk("midreset_irq", irq, 4'b0000);
        chk("midreset_overflow", overflow, 4'b0000);
        irq_raw = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("post_reset_k%0d_pending", k), pending, 4'b0000);
        end

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
`ifdef IRQ_GLITCH_FILTER_EN
                if ($urandom_range(0, 5) == 0) irq_raw[i] = ~irq_raw[i];
`else
                if ($urandom_range(0, 3) == 0) irq_raw[i] = ~irq_raw[i];
`endif
            end
            if ($urandom_range(0, 31) == 0) edge_mode = 4'($urandom_range(0, 15));
            if ((c % 8) == 0) irq_mask = 4'($urandom_range(0, 15));
            int_ack = ($urandom_range(0, 3) == 0);
            int_id  = 2'($urandom_range(0, 3));
            ovf_clr = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
